// File: rtl/shift_frame_reg.sv
// shift_frame_reg: bidirectional serial shift register with parallel load and frame capture.
// Optional macro SHIFT_FRAME_PARITY_EN adds a registered even-parity output frame_par.
`default_nettype none

module shift_frame_reg #(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pulse_val,
  input  logic                     sdi,
  input  logic                     dir,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pdata,
  output logic [WIDTH-1:0]         q,
  output logic                     sdo,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         frame_q,
`ifdef SHIFT_FRAME_PARITY_EN
  output logic                     frame_par,
`endif
  output logic                     frame_valid
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] frm_q,   frm_d;
  logic             fvld_q,  fvld_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    fvld_d  = 1'b0;
    if (load) begin
      shreg_d = pdata;
      cnt_d   = '0;
    end else if (pulse_val) begin
      shreg_d = dir ? {shreg_q[WIDTH-2:0], sdi} : {sdi, shreg_q[WIDTH-1:1]};
      if (cnt_q == CNT_LAST) begin
        // Captured value is the post-shift register, so q and frame_q match on the pulse.
        cnt_d  = '0;
        frm_d  = shreg_d;
        fvld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= RST_VAL;
      cnt_q   <= '0;
      frm_q   <= '0;
      fvld_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      fvld_q  <= fvld_d;
    end
  end

`ifdef SHIFT_FRAME_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (fvld_d) begin
      par_q <= ^frm_d;
    end
  end

  assign frame_par = par_q;
`endif

  assign q           = shreg_q;
  assign sdo         = dir ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bit_cnt     = cnt_q;
  assign frame_q     = frm_q;
  assign frame_valid = fvld_q;

endmodule

`default_nettype wire

// File: doc/shift_frame_reg.md
Name: shift_frame_reg

Overview:
Parametrised successor of the 10-bit serial-in shift register. Adds bidirectional shifting, parallel load, a serial output and a bit counter that captures each completed WIDTH-bit frame. Sits between a serial front end (strobed by a one-cycle pulse from the debounce/pulse generator) and the parallel datapath or display logic.

Parameters:
WIDTH, 10, register and frame length in bits; legal range is WIDTH >= 2.
RST_VAL, 0, reset value loaded into q; WIDTH bits wide.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
pulse_val  input  1  shift strobe; one shift per cycle while high.
sdi  input  1  serial data in.
dir  input  1  0 = shift right (sdi enters MSB), 1 = shift left (sdi enters LSB).
load  input  1  parallel load strobe.
pdata  input  WIDTH  parallel load data.
q  output  WIDTH  shift register contents (registered).
sdo  output  1  serial data out; combinational from q.
bit_cnt  output  $clog2(WIDTH)  number of shifts taken in the current frame (registered).
frame_q  output  WIDTH  last completed frame (registered).
frame_valid  output  1  one-cycle pulse when frame_q updates.

Behaviour:
- Reset is asynchronous and active-low. While rst = 0: q = RST_VAL, bit_cnt = 0, frame_q = 0, frame_valid = 0. These values take effect immediately, not on the next edge. Release is synchronous to the next clk edge.
- Per-cycle priority is load, then pulse_val, then hold.
- load = 1:
  - q <= pdata and bit_cnt <= 0.
  - frame_q is held and frame_valid <= 0.
  - pulse_val is ignored in the same cycle.
- pulse_val = 1, dir = 0: q <= {sdi, q[WIDTH-1:1]}. This is the original behaviour.
- pulse_val = 1, dir = 1: q <= {q[WIDTH-2:0], sdi}.
- sdo = q[0] when dir = 0 and q[WIDTH-1] when dir = 1. It is the bit leaving on the next shift. No added latency.
- Bit counter:
  - Each accepted shift increments bit_cnt.
  - When bit_cnt = WIDTH-1 and a shift is accepted: bit_cnt wraps to 0, frame_q <= the post-shift value of q, and frame_valid <= 1 for exactly one cycle.
  - frame_q and q are therefore equal in the cycle frame_valid is high.
- frame_valid is 0 in every cycle that has no frame completion. Back-to-back frames give one pulse per frame.
- Changing dir mid-frame does not reset bit_cnt; frame completion is still counted in shifts.
- A held cycle (no load, no pulse) keeps all registers unchanged and frame_valid = 0.
- Reset mid-frame discards the partial frame; the count restarts from 0.
- No metastability handling inside the block; sdi, dir, load and pulse_val must be synchronous to clk.

Optional Feature:
SHIFT_FRAME_PARITY_EN
- Defined:
  - Adds output frame_par, 1 bit, registered.
  - frame_par = XOR of all bits of frame_q (even parity), updated in the same cycle as frame_q.
  - Reset value 0.
- Undefined: port frame_par is absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst = 0 mid-clock with RST_VAL = 10'h155 -> q = 10'h155, bit_cnt = 0, frame_q = 0, frame_valid = 0, all before the next edge.
- Right frame, WIDTH = 10, dir = 0: sdi sequence 1,0,1,1,0,0,1,1,1,0, with pulse_val high on 10 consecutive cycles.
  - After the 10th edge: q = 10'h1CD, frame_q = 10'h1CD, frame_valid high for 1 cycle, bit_cnt = 0.
  - With SHIFT_FRAME_PARITY_EN defined: frame_par = 0.
- Left frame, dir = 1, same sequence: q = frame_q = 10'h2CE, one frame_valid pulse. sdo tracks q[9] before each shift.
- Load mid-frame: after 4 shifts assert load with pdata = 10'h3FF together with pulse_val.
  - Result: q = 10'h3FF, bit_cnt = 0, no frame_valid.
  - A further 9 shifts give no pulse; the 10th gives a pulse.
- Gapped strobes: 10 pulses separated by 0–3 idle cycles -> exactly one frame_valid pulse, and q holds across idle cycles.
- Reset mid-frame: drive rst low after 5 shifts, then release and do 10 shifts.
  - During reset: q = RST_VAL, bit_cnt = 0.
  - After release: the pulse arrives only on the 10th post-reset shift.
